// File: rtl/scan_ctrl_pkg.sv
// Shared state encoding and default widths for the 2-D address scan controller.
package scan_ctrl_pkg;

  localparam int unsigned ROW_W_DEF = 4;
  localparam int unsigned COL_W_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scan_cnt.sv
// Up-counter with enable, synchronous clear (clear wins) and async active-low reset.
module scan_cnt #(
  parameter int unsigned SIZE = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_clr,
  output logic [SIZE-1:0] o_cnt
);

  logic [SIZE-1:0] r_cnt;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + SIZE'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/scan_ctrl.sv
// 2-D (row, col) address scan sequencer: column inner loop, row outer loop,
// start/done handshake on the control side and valid/ready beats to the consumer.
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int unsigned ROW_W = ROW_W_DEF,
  parameter int unsigned COL_W = COL_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [ROW_W-1:0] rows_m1,
  input  logic [COL_W-1:0] cols_m1,
  output logic             addr_valid,
  input  logic             addr_ready,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last,
  output logic             busy,
  output logic             done
);

  state_e           r_state;
  logic [ROW_W-1:0] r_rows_m1;
  logic [COL_W-1:0] r_cols_m1;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_in_scan;
  logic             w_launch;
  logic             w_abort;
  logic             w_adv;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_last_pos;

  // Handshake qualification and terminal compares against the latched bounds.
  always_comb begin
    w_in_scan  = (r_state == S_SCAN);
    w_launch   = (r_state == S_IDLE) && start;
    w_abort    = w_in_scan && abort;
    // Abort wins over a same-cycle fire: the beat is not accepted.
    w_adv      = w_in_scan && addr_ready && !abort;
    w_col_end  = (w_col == r_cols_m1);
    w_row_end  = (w_row == r_rows_m1);
    w_last_pos = w_col_end && w_row_end;
  end

  scan_cnt #(
    .SIZE(COL_W)
  ) u_col_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_adv),
    .i_clr(w_launch || w_abort || (w_adv && w_col_end)),
    .o_cnt(w_col)
  );

  scan_cnt #(
    .SIZE(ROW_W)
  ) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_adv && w_col_end),
    .i_clr(w_launch || w_abort || (w_adv && w_last_pos)),
    .o_cnt(w_row)
  );

  // Control FSM with registered valid/busy/done and bounds latched at start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_rows_m1 <= '0;
      r_cols_m1 <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_rows_m1 <= rows_m1;
            r_cols_m1 <= cols_m1;
            r_state   <= S_SCAN;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_SCAN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
          end else if (addr_ready && w_last_pos) begin
            r_state <= S_DONE;
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign addr_valid = r_valid;
  assign busy       = r_busy;
  assign done       = r_done;
  assign row        = w_row;
  assign col        = w_col;
  assign last       = w_in_scan && w_last_pos;

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: stimulus queues expected beats and done pulses,
// a negedge monitor pops and checks each accepted beat and each done pulse.
module tb_scan_ctrl;

  localparam int RW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          addr_ready = 1'b0;
  logic [RW-1:0] rows_m1 = '0;
  logic [CW-1:0] cols_m1 = '0;
  logic          addr_valid;
  logic          last;
  logic          busy;
  logic          done;
  logic [RW-1:0] row;
  logic [CW-1:0] col;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] c;
    logic       l;
  } beat_t;

  beat_t exp_q[$];
  int    done_want = 0;
  int    done_seen = 0;
  int    total = 0;
  int    bad = 0;

  scan_ctrl #(
    .ROW_W(RW),
    .COL_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .rows_m1   (rows_m1),
    .cols_m1   (cols_m1),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .row       (row),
    .col       (col),
    .last      (last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    if (rst && addr_valid && addr_ready && !abort) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'({row, col, last}), 32'hFFFF_FFFF);
      end else begin
        beat_t b;
        b = exp_q.pop_front();
        check("beat", 32'({row, col, last}), 32'({b.r, b.c, b.l}));
      end
    end
    if (done) begin
      done_seen++;
      check("done_expected", 32'(done_seen <= done_want), 32'd1);
    end
  end

  task automatic push_scan(input int rr, input int cc);
    for (int r = 0; r <= rr; r++) begin
      for (int c = 0; c <= cc; c++) begin
        beat_t b;
        b.r = 4'(r);
        b.c = 4'(c);
        b.l = (r == rr) && (c == cc);
        exp_q.push_back(b);
      end
    end
    done_want++;
  endtask

  // Returns one cycle after the start edge, DUT showing (0,0).
  task automatic start_scan(input int rr, input int cc, input logic rdy);
    @(posedge clk); #1;
    rows_m1 = 4'(rr);
    cols_m1 = 4'(cc);
    start   = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    addr_ready = rdy;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic idle_check(input string name);
    check(name, 32'({addr_valid, busy, done, last, row, col}), 32'd0);
  endtask

  initial begin
    int n;

    // Test 1: reset state, then reset mid-scan.
    #12;
    idle_check("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.push_back('{r: 4'd0, c: 4'd0, l: 1'b0});
    exp_q.push_back('{r: 4'd0, c: 4'd1, l: 1'b0});
    exp_q.push_back('{r: 4'd0, c: 4'd2, l: 1'b0});
    exp_q.push_back('{r: 4'd0, c: 4'd3, l: 1'b0});
    exp_q.push_back('{r: 4'd1, c: 4'd0, l: 1'b0});
    start_scan(3, 3, 1'b1);
    check("t1_first_beat", 32'({addr_valid, busy, row, col}), 32'({2'b11, 4'd0, 4'd0}));
    repeat (5) @(posedge clk);
    #1;
    check("t1_beat5_pos", 32'({row, col}), 32'({4'd1, 4'd1}));
    #1;
    rst = 1'b0;
    #1;
    idle_check("t1_async_reset");
    repeat (3) @(posedge clk);
    #1;
    idle_check("t1_held_reset");
    rst        = 1'b1;
    addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle_check("t1_after_release");
    check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t1_no_done", 32'(done_seen), 32'(done_want));

    // Test 2: full 3x4 scan with ready held high.
    push_scan(2, 3);
    start_scan(2, 3, 1'b1);
    wait_done(n);
    check("t2_done_latency", 32'(n), 32'd12);
    check("t2_busy_with_done", 32'({busy, addr_valid}), 32'({1'b1, 1'b0}));
    @(posedge clk); #1;
    idle_check("t2_idle_after");
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t2_done_count", 32'(done_seen), 32'(done_want));

    // Test 3: stall on a 1x2 scan, ready 1,0,0,1.
    push_scan(0, 1);
    start_scan(0, 1, 1'b1);
    @(posedge clk); #1;
    addr_ready = 1'b0;
    check("t3_hold1", 32'({addr_valid, row, col, last}), 32'({1'b1, 4'd0, 4'd1, 1'b1}));
    @(posedge clk); #1;
    check("t3_hold2", 32'({addr_valid, row, col, last}), 32'({1'b1, 4'd0, 4'd1, 1'b1}));
    addr_ready = 1'b1;
    @(posedge clk); #1;
    check("t3_done", 32'({done, busy, addr_valid}), 32'({1'b1, 1'b1, 1'b0}));
    @(posedge clk); #1;
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t3_done_count", 32'(done_seen), 32'(done_want));

    // Test 4: degenerate 1x1 scan.
    push_scan(0, 0);
    start_scan(0, 0, 1'b1);
    check("t4_beat", 32'({addr_valid, busy, last, done}), 32'({1'b1, 1'b1, 1'b1, 1'b0}));
    @(posedge clk); #1;
    check("t4_done", 32'({addr_valid, busy, last, done}), 32'({1'b0, 1'b1, 1'b0, 1'b1}));
    @(posedge clk); #1;
    idle_check("t4_idle");
    check("t4_done_count", 32'(done_seen), 32'(done_want));

    // Test 5: abort at (1,2) of a 3x3 scan with a same-cycle fire.
    exp_q.push_back('{r: 4'd0, c: 4'd0, l: 1'b0});
    exp_q.push_back('{r: 4'd0, c: 4'd1, l: 1'b0});
    exp_q.push_back('{r: 4'd0, c: 4'd2, l: 1'b0});
    exp_q.push_back('{r: 4'd1, c: 4'd0, l: 1'b0});
    exp_q.push_back('{r: 4'd1, c: 4'd1, l: 1'b0});
    start_scan(2, 2, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t5_abort_pos", 32'({row, col}), 32'({4'd1, 4'd2}));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    idle_check("t5_after_abort");
    repeat (3) @(posedge clk);
    #1;
    idle_check("t5_still_idle");
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t5_no_done", 32'(done_seen), 32'(done_want));
    push_scan(0, 1);
    start_scan(0, 1, 1'b1);
    check("t5_restart", 32'({addr_valid, row, col}), 32'({1'b1, 4'd0, 4'd0}));
    wait_done(n);
    @(posedge clk); #1;
    check("t5_restart_empty", 32'(exp_q.size()), 32'd0);

    // Test 6: start and bound changes during the scan are ignored.
    push_scan(1, 1);
    start_scan(1, 1, 1'b1);
    start   = 1'b1;
    rows_m1 = 4'd3;
    cols_m1 = 4'd3;
    wait_done(n);
    check("t6_done_latency", 32'(n), 32'd4);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_check("t6_no_second_scan");
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t6_done_count", 32'(done_seen), 32'(done_want));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
